// File: rtl/descrambler_23b.sv
// descrambler_23b: byte-wide descrambler for 130b blocks with a 23-bit LFSR.
// Frames incoming bytes into DATA or ordered-set (OS) blocks from the sync
// header that arrives with blk_start. DATA bytes are XORed with the keystream
// when descram_en is high. OS bytes pass through untouched. A SKP ordered set
// (byte 0 = 8'hAA) freezes the LFSR. An EIEOS (byte 0 = 8'h00) raises
// eieos_det once the block completes.
// Optional build macro: DESCRAM_EIEOS_RESET_EN. When it is defined, the LFSR
// also reloads to SEED on the cycle eieos_det pulses.
module descrambler_23b #(
    parameter logic [22:0] SEED      = 23'h1DBFBC,
    parameter int unsigned BLK_BYTES = 16
) (
    input  logic       clk_1G,
    input  logic       rst_1G,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       blk_start,
    input  logic [1:0] sync_hdr,
    input  logic       descram_en,
    input  logic       lfsr_clr,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_is_os,
    output logic       blk_err,
    output logic       eieos_det
);

    localparam int unsigned CNT_W = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Feedback taps: bits that take LR[i-1] ^ LR[22] on each serial step.
    localparam logic [22:0] TAP_MASK = 23'h210124;   // bits 21,16,8,5,2

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_OS   = 2'b01;
    localparam logic [7:0] SKP_SYM   = 8'hAA;
    localparam logic [7:0] EIEOS_SYM = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_OS   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [22:0]      lfsr_reg, lfsr_next;
    logic             skp_reg, skp_next;
    logic             eieos_blk_reg, eieos_blk_next;

    logic [7:0]       dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             dout_is_os_reg, dout_is_os_next;
    logic             blk_err_reg, blk_err_next;
    logic             eieos_det_reg, eieos_det_next;

    logic [7:0]       ks;
    logic [22:0]      lfsr_adv;
    logic [22:0]      lfsr_walk;

    logic             accept_byte;
    logic             is_os_byte;
    logic             last_byte;
    logic             advance;
    logic [CNT_W-1:0] byte_idx;

    // One serial LFSR step; the bit shifted out of LR[22] feeds LR[0] and the taps.
    function automatic logic [22:0] lfsr_step(input logic [22:0] s);
        lfsr_step = {s[21:0], s[22]} ^ ({23{s[22]}} & TAP_MASK);
    endfunction

    // Eight serial steps per byte: the first bit shifted out is keystream bit 7.
    always_comb begin
        lfsr_walk = lfsr_reg;
        ks        = '0;
        for (int i = 0; i < 8; i++) begin
            ks[7 - i] = lfsr_walk[22];
            lfsr_walk = lfsr_step(lfsr_walk);
        end
        lfsr_adv = lfsr_walk;
    end

    // Framing state register.
    always_ff @(posedge clk_1G or negedge rst_1G) begin
        if (!rst_1G) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Framing decisions, byte processing and LFSR update for the current byte.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        lfsr_next       = lfsr_reg;
        skp_next        = skp_reg;
        eieos_blk_next  = eieos_blk_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        dout_is_os_next = 1'b0;
        blk_err_next    = 1'b0;
        eieos_det_next  = 1'b0;
        accept_byte     = 1'b0;
        is_os_byte      = 1'b0;
        last_byte       = 1'b0;
        advance         = 1'b0;
        byte_idx        = cnt_reg;

        if (rx_valid) begin
            if (blk_start) begin
                // A block start is only legal when no block is open; either way
                // framing restarts with this byte as byte 0.
                blk_err_next = (state_reg != S_IDLE);
                byte_idx     = '0;
                if (sync_hdr == HDR_DATA) begin
                    accept_byte    = 1'b1;
                    skp_next       = 1'b0;
                    eieos_blk_next = 1'b0;
                    state_next     = S_DATA;
                end else if (sync_hdr == HDR_OS) begin
                    accept_byte    = 1'b1;
                    is_os_byte     = 1'b1;
                    skp_next       = (rx_data == SKP_SYM);
                    eieos_blk_next = (rx_data == EIEOS_SYM);
                    state_next     = S_OS;
                end else begin
                    // Invalid header: drop the byte and wait for a clean block start.
                    blk_err_next = 1'b1;
                    state_next   = S_IDLE;
                    cnt_next     = '0;
                end
            end else if (state_reg == S_IDLE) begin
                // Stray byte outside any block.
                blk_err_next = 1'b1;
            end else begin
                accept_byte = 1'b1;
                is_os_byte  = (state_reg == S_OS);
            end
        end

        if (accept_byte) begin
            last_byte       = (byte_idx == CNT_LAST);
            cnt_next        = last_byte ? '0 : (byte_idx + CNT_ONE);
            if (last_byte) begin
                state_next = S_IDLE;
            end
            dout_valid_next = 1'b1;
            dout_is_os_next = is_os_byte;
            if (is_os_byte) begin
                dout_next      = rx_data;
                advance        = !skp_next;
                eieos_det_next = last_byte && eieos_blk_next;
            end else begin
                dout_next = descram_en ? (rx_data ^ ks) : rx_data;
                advance   = 1'b1;
            end
            if (advance) begin
                lfsr_next = lfsr_adv;
            end
        end

`ifdef DESCRAM_EIEOS_RESET_EN
        // A completed EIEOS realigns the keystream.
        if (eieos_det_next) begin
            lfsr_next = SEED;
        end
`endif

        // An explicit clear overrides any advance; the current byte has already
        // used the pre-clear keystream.
        if (lfsr_clr) begin
            lfsr_next = SEED;
        end
    end

    // Datapath registers: counter, LFSR, block flags and registered outputs.
    always_ff @(posedge clk_1G or negedge rst_1G) begin
        if (!rst_1G) begin
            cnt_reg        <= '0;
            lfsr_reg       <= SEED;
            skp_reg        <= 1'b0;
            eieos_blk_reg  <= 1'b0;
            dout_reg       <= 8'h00;
            dout_valid_reg <= 1'b0;
            dout_is_os_reg <= 1'b0;
            blk_err_reg    <= 1'b0;
            eieos_det_reg  <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            lfsr_reg       <= lfsr_next;
            skp_reg        <= skp_next;
            eieos_blk_reg  <= eieos_blk_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            dout_is_os_reg <= dout_is_os_next;
            blk_err_reg    <= blk_err_next;
            eieos_det_reg  <= eieos_det_next;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_is_os = dout_is_os_reg;
    assign blk_err    = blk_err_reg;
    assign eieos_det  = eieos_det_reg;

endmodule

// File: tb/tb_descrambler_23b.sv
// Self-checking bench for descrambler_23b: a vector table for framing and
// error handling, plus hand-written block sequences for the keystream cases.
module tb_descrambler_23b;

    localparam logic [22:0] SEED_TB = 23'h1DBFBC;

    logic       clk_1G = 1'b0;
    logic       rst_1G;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       blk_start;
    logic [1:0] sync_hdr;
    logic       descram_en;
    logic       lfsr_clr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_is_os;
    logic       blk_err;
    logic       eieos_det;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic       st;
        logic [1:0] hdr;
        logic [7:0] d;
        logic       en;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       eos;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    always #5 clk_1G = ~clk_1G;

    descrambler_23b dut (
        .clk_1G     (clk_1G),
        .rst_1G     (rst_1G),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .blk_start  (blk_start),
        .sync_hdr   (sync_hdr),
        .descram_en (descram_en),
        .lfsr_clr   (lfsr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_is_os (dout_is_os),
        .blk_err    (blk_err),
        .eieos_det  (eieos_det)
    );

    // Reference LFSR step written bit by bit from the tap list.
    function automatic logic [22:0] model_step(input logic [22:0] r);
        logic [22:0] n;
        n[0] = r[22];
        for (int i = 1; i < 23; i++) begin
            if (i == 2 || i == 5 || i == 8 || i == 16 || i == 21)
                n[i] = r[i-1] ^ r[22];
            else
                n[i] = r[i-1];
        end
        return n;
    endfunction

    // Keystream byte number n counted from SEED (byte 0 is the first one).
    function automatic logic [7:0] model_ks(input int n);
        logic [22:0] r;
        logic [7:0]  k;
        r = SEED_TB;
        k = '0;
        for (int b = 0; b < n * 8; b++) r = model_step(r);
        for (int s = 0; s < 8; s++) begin
            k[7 - s] = r[22];
            r = model_step(r);
        end
        return k;
    endfunction

    function automatic vec_t mk(input logic v, input logic st, input logic [1:0] hdr,
                                input logic [7:0] d, input logic en, input logic clr,
                                input logic ev, input logic [7:0] ed,
                                input logic eos, input logic eerr);
        vec_t t;
        t.v = v; t.st = st; t.hdr = hdr; t.d = d; t.en = en; t.clr = clr;
        t.ev = ev; t.ed = ed; t.eos = eos; t.eerr = eerr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one input cycle, then sample the registered outputs 1 ns after the edge.
    task automatic drive(input logic v, input logic st, input logic [1:0] hdr,
                         input logic [7:0] d, input logic en, input logic clr);
        rx_valid   = v;
        blk_start  = st;
        sync_hdr   = hdr;
        rx_data    = d;
        descram_en = en;
        lfsr_clr   = clr;
        @(posedge clk_1G);
        #1;
        $display("txn v=%0d st=%0d hdr=%b d=%02h en=%0d clr=%0d -> dout=%02h dv=%0d os=%0d err=%0d eieos=%0d",
                 v, st, hdr, d, en, clr, dout, dout_valid, dout_is_os, blk_err, eieos_det);
    endtask

    task automatic do_reset();
        rst_1G     = 1'b0;
        rx_valid   = 1'b0;
        blk_start  = 1'b0;
        sync_hdr   = 2'b00;
        rx_data    = 8'h00;
        descram_en = 1'b0;
        lfsr_clr   = 1'b0;
        repeat (2) @(posedge clk_1G);
        #1;
        rst_1G = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [7:0] exp_b;
        logic [7:0] pat;

        // ---------------- reset state ----------------
        rst_1G     = 1'b0;
        rx_valid   = 1'b1;
        blk_start  = 1'b1;
        sync_hdr   = 2'b10;
        rx_data    = 8'h5A;
        descram_en = 1'b1;
        lfsr_clr   = 1'b0;
        repeat (3) @(posedge clk_1G);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout_is_os", dout_is_os, 1'b0);
        chk("rst_blk_err", blk_err, 1'b0);
        chk("rst_eieos_det", eieos_det, 1'b0);
        do_reset();

        // ---------------- DATA block, first keystream byte 8'h36 ----------------
        drive(1, 1, 2'b10, 8'h36, 1, 0);
        chk("d0_dout", dout, 8'h00);
        chk("d0_valid", dout_valid, 1'b1);
        chk("d0_is_os", dout_is_os, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1, 0, 2'b00, model_ks(i), 1, 0);
            chk($sformatf("d%0d_dout", i), dout, 8'h00);
            chk($sformatf("d%0d_valid", i), dout_valid, 1'b1);
        end
        // Block closed: a byte without blk_start is a framing error.
        drive(1, 0, 2'b00, 8'h12, 1, 0);
        chk("idle_stray_err", blk_err, 1'b1);
        chk("idle_stray_valid", dout_valid, 1'b0);

        // ---------------- pass-through still advances the LFSR ----------------
        do_reset();
        drive(1, 1, 2'b10, 8'h00, 0, 0);
        chk("pt0_dout", dout, 8'h00);
        for (int i = 1; i < 16; i++) begin
            drive(1, 0, 2'b00, 8'(i * 3), 0, 0);
            chk($sformatf("pt%0d_dout", i), dout, 8'(i * 3));
        end
        drive(1, 1, 2'b10, 8'h36, 1, 0);
        chk("pt_next_ne0", (dout != 8'h00), 1'b1);
        chk("pt_next_dout", dout, 8'h36 ^ model_ks(16));

        // ---------------- SKP ordered set freezes the LFSR ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pat = (i == 0) ? 8'hAA : 8'(8'h30 + i);
            drive(1, (i == 0), 2'b01, pat, 1, 0);
            chk($sformatf("skp%0d_dout", i), dout, pat);
            chk($sformatf("skp%0d_is_os", i), dout_is_os, 1'b1);
        end
        chk("skp_no_eieos", eieos_det, 1'b0);
        drive(1, 1, 2'b10, 8'h36, 1, 0);
        chk("skp_then_data", dout, 8'h00);
        chk("skp_then_data_os", dout_is_os, 1'b0);

        // ---------------- EIEOS ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pat = (i == 0) ? 8'h00 : 8'(8'hF0 ^ i);
            drive(1, (i == 0), 2'b01, pat, 1, 0);
            chk($sformatf("eieos%0d_det", i), eieos_det, (i == 15));
            chk($sformatf("eieos%0d_dout", i), dout, pat);
        end
        drive(0, 0, 2'b00, 8'h00, 0, 0);
        chk("eieos_pulse_once", eieos_det, 1'b0);
        drive(1, 1, 2'b10, 8'h36, 1, 0);
`ifdef DESCRAM_EIEOS_RESET_EN
        exp_b = 8'h00;
`else
        exp_b = 8'h36 ^ model_ks(16);
`endif
        chk("eieos_then_data", dout, exp_b);

        // ---------------- table: header errors, restart, stall, clear ----------------
        do_reset();
        tbl.push_back(mk(1, 1, 2'b11, 8'h55, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b10, 8'h36, 1, 0, 1, 8'h00, 0, 0));
        for (int k = 1; k < 7; k++) begin
            tbl.push_back(mk(1, 0, 2'b00, 8'(8'h10 + k), 0, 0, 1, 8'(8'h10 + k), 0, 0));
            if (k == 2) tbl.push_back(mk(0, 0, 2'b00, 8'hEE, 0, 0, 0, 8'h00, 0, 0));
        end
        tbl.push_back(mk(1, 1, 2'b10, 8'h77, 0, 0, 1, 8'h77, 0, 1));
        for (int k = 1; k < 16; k++)
            tbl.push_back(mk(1, 0, 2'b00, 8'(8'h80 + k), 0, 0, 1, 8'(8'h80 + k), 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 8'h99, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b10, 8'h42, 0, 1, 1, 8'h42, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 8'h36, 1, 0, 1, 8'h00, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].hdr, tbl[i].d, tbl[i].en, tbl[i].clr);
            chk($sformatf("tbl%0d_valid", i), dout_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_err", i), blk_err, tbl[i].eerr);
            chk($sformatf("tbl%0d_os", i), dout_is_os, tbl[i].eos);
            if (tbl[i].ev) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
        end

        // ---------------- asynchronous reset mid-block ----------------
        #2;
        rst_1G = 1'b0;
        #1;
        chk("async_rst_valid", dout_valid, 1'b0);
        chk("async_rst_dout", dout, 8'h00);
        @(posedge clk_1G);
        #1;
        rst_1G = 1'b1;
        drive(1, 0, 2'b00, 8'h21, 1, 0);
        chk("post_rst_nostart_err", blk_err, 1'b1);
        chk("post_rst_nostart_valid", dout_valid, 1'b0);
        drive(1, 1, 2'b10, 8'h36, 1, 0);
        chk("post_rst_data", dout, 8'h00);

        // ---------------- stalled DATA block matches the unstalled keystream ----------------
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            pat = 8'(i * 37 + 5);
            drive(1, (i == 0), 2'b10, pat, 1, 0);
            if (dout_valid) pulses++;
            chk($sformatf("stall%0d_dout", i), dout, pat ^ model_ks(i));
            drive(0, 0, 2'b00, 8'hFF, 1, 0);
            if (dout_valid) pulses++;
            chk($sformatf("stall%0d_gap", i), dout_valid, 1'b0);
        end
        chk("stall_pulses", pulses, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
